// File: rtl/uop_cache_pkg.sv
// rtl/uop_cache_pkg.sv - shared types and defaults for the loop-buffer controller
// Parity helper exists only when UOP_CACHE_PARITY_EN is defined.
package uop_cache_pkg;

  localparam int UOP_DEPTH_DEF  = 8;
  localparam int UOP_DATA_W_DEF = 32;
  localparam int UOP_PAR_MAX_W  = 256;

  typedef logic [$clog2(UOP_DEPTH_DEF)-1:0] uop_cache_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LOCKED,
    ST_REPLAY,
    ST_INVAL
  } uop_state_t;

`ifdef UOP_CACHE_PARITY_EN
  // Zero extension leaves parity unchanged, so one wide helper serves any width.
  function automatic logic uop_parity(input logic [UOP_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uop_cache_ctrl.sv
// rtl/uop_cache_ctrl.sv - single-port loop-buffer RAM sequencer: fill, replay, invalidate
// Optional stored-parity protection with UOP_CACHE_PARITY_EN.
module uop_cache_ctrl
  import uop_cache_pkg::*;
#(
  parameter int DEPTH  = UOP_DEPTH_DEF,
  parameter int DATA_W = UOP_DATA_W_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
`ifdef UOP_CACHE_PARITY_EN
  localparam int MW = DATA_W + 1
`else
  localparam int MW = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              fill_last,
  output logic              fill_ready,
  input  logic              rep_req,
  input  logic              rep_ready,
  output logic              rep_valid,
  output logic [DATA_W-1:0] rep_data,
  input  logic              inv_req,
  output logic              inv_done,
  output logic              overflow,
`ifdef UOP_CACHE_PARITY_EN
  output logic              par_err,
`endif
  output logic [CW-1:0]     count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [MW-1:0]     mem_wdata,
  input  logic [MW-1:0]     mem_rdata
);

  uop_state_t        state, state_nxt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              rd_pend, out_valid;
  logic [DATA_W-1:0] out_data;
  logic              fill_hs, rd_issue, rd_ok, par_bad, word_vis, rd_last, last_entry;
  logic [MW-1:0]     fill_word;

`ifdef UOP_CACHE_PARITY_EN
  assign fill_word = {uop_parity(UOP_PAR_MAX_W'(fill_data)), fill_data};
  assign rd_ok     = (mem_rdata[MW-1] == uop_parity(UOP_PAR_MAX_W'(mem_rdata[DATA_W-1:0])));
`else
  assign fill_word = fill_data;
  assign rd_ok     = 1'b1;
`endif

  assign fill_hs    = fill_valid & ~inv_req & ~reset & ((state == ST_IDLE) || (state == ST_FILL));
  assign fill_ready = fill_hs;
  assign last_entry = (wr_ptr == AW'(DEPTH - 1));
  assign rd_last    = ({1'b0, rd_ptr} == (count - CW'(1)));
  assign par_bad    = rd_pend & ~rd_ok;

  // Returning read data is presented straight from the RAM; the output register
  // only catches it when the consumer stalls, keeping at most one word visible.
  assign word_vis  = out_valid | (rd_pend & rd_ok);
  assign rep_valid = word_vis;
  assign rep_data  = (!out_valid && rd_pend) ? mem_rdata[DATA_W-1:0] : out_data;

  assign rd_issue = (state == ST_REPLAY) & rep_req & ~inv_req & ~par_bad &
                    (~word_vis | rep_ready);

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_INVAL: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wr_ptr;
        if (last_entry) state_nxt = ST_IDLE;
      end
      default: begin
        if (inv_req || par_bad) begin
          state_nxt = ST_INVAL;
        end else if (fill_hs) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_ptr;
          mem_wdata = fill_word;
          if (fill_last)       state_nxt = ST_LOCKED;
          else if (last_entry) state_nxt = ST_INVAL;
          else                 state_nxt = ST_FILL;
        end else if (state == ST_LOCKED && rep_req) begin
          state_nxt = ST_REPLAY;
        end else if (state == ST_REPLAY) begin
          if (!rep_req) begin
            state_nxt = ST_LOCKED;
          end else if (rd_issue) begin
            mem_en   = 1'b1;
            mem_addr = rd_ptr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      inv_done  <= 1'b0;
      overflow  <= 1'b0;
`ifdef UOP_CACHE_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      rd_pend  <= rd_issue;
      inv_done <= 1'b0;
      overflow <= 1'b0;
`ifdef UOP_CACHE_PARITY_EN
      par_err  <= 1'b0;
`endif
      if (state == ST_INVAL) begin
        // wr_ptr doubles as the clear index and wraps back to 0 on the last write.
        wr_ptr <= wr_ptr + AW'(1);
        if (last_entry) begin
          inv_done <= 1'b1;
          count    <= '0;
          rd_ptr   <= '0;
        end
      end else if (state_nxt == ST_INVAL) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        out_valid <= 1'b0;
        overflow  <= fill_hs & ~fill_last & last_entry;
`ifdef UOP_CACHE_PARITY_EN
        par_err   <= par_bad;
`endif
      end else begin
        if (fill_hs) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (fill_last) count <= {1'b0, wr_ptr} + CW'(1);
        end
        if (state == ST_REPLAY && !rep_req) begin
          out_valid <= 1'b0;
          rd_ptr    <= '0;
        end else begin
          if (rd_issue) rd_ptr <= rd_last ? '0 : rd_ptr + AW'(1);
          if (rd_pend && rd_ok && !rep_ready) begin
            out_valid <= 1'b1;
            out_data  <= mem_rdata[DATA_W-1:0];
          end else if (out_valid && rep_ready) begin
            out_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uop_cache_ctrl.sv
// tb/tb_uop_cache_ctrl.sv - self-checking bench for uop_cache_ctrl with a behavioural RAM
// Parity scenario is included when UOP_CACHE_PARITY_EN is defined.
module tb_uop_cache_ctrl;
  import uop_cache_pkg::*;

`ifdef UOP_CACHE_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fill_valid, fill_last, fill_ready;
  logic [31:0] fill_data;
  logic        rep_req, rep_ready, rep_valid;
  logic [31:0] rep_data;
  logic        inv_req, inv_done, overflow;
`ifdef UOP_CACHE_PARITY_EN
  logic        par_err;
`endif
  logic [3:0]  count;
  logic        mem_en, mem_we;
  logic [2:0]  mem_addr;
  logic [MW-1:0] mem_wdata, mem_rdata;

  uop_cache_ctrl #(.DEPTH(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_last(fill_last), .fill_ready(fill_ready),
    .rep_req(rep_req), .rep_ready(rep_ready), .rep_valid(rep_valid), .rep_data(rep_data),
    .inv_req(inv_req), .inv_done(inv_done), .overflow(overflow),
`ifdef UOP_CACHE_PARITY_EN
    .par_err(par_err),
`endif
    .count(count), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] ram [8];
  logic          corrupt = 1'b0;
  uop_cache_addr_t bad_addr = 3'd1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr] ^ ((corrupt && mem_addr == bad_addr) ? MW'(32'h20) : MW'(0));
    end
  end

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [31:0] exp_q [$];
  logic [31:0] w [8];
  logic        held_v = 1'b0;
  logic [31:0] held_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted replay word must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset) begin
      if (held_v && rep_valid) chk("rep_hold", 64'(rep_data), 64'(held_d));
      if (rep_valid && rep_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rep_extra actual=%0h required=no_word", rep_data);
        end else begin
          chk("rep_data", 64'(rep_data), 64'(exp_q.pop_front()));
        end
        delivered++;
      end
      held_v = rep_valid && !rep_ready;
      held_d = rep_data;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic check_inval(input string tag, input bit exp_ovf, input bit exp_par);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, "_we"}, 64'(mem_en & mem_we), 64'd1);
      chk({tag, "_addr"}, 64'(mem_addr), 64'(i));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, "_early_done"}, 64'(inv_done), 64'd0);
      chk({tag, "_rv"}, 64'(rep_valid), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow), (i == 0 && exp_ovf) ? 64'd1 : 64'd0);
`ifdef UOP_CACHE_PARITY_EN
      chk({tag, "_par"}, 64'(par_err), (i == 0 && exp_par) ? 64'd1 : 64'd0);
`endif
      tick();
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(inv_done), 64'd1);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_idle_en"}, 64'(mem_en), 64'd0);
    tick();
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(inv_done), 64'd0);
    tick();
  endtask

  task automatic fill_loop(input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      fill_valid = 1'b1;
      fill_data  = w[i];
      fill_last  = close && (i == n - 1);
      @(negedge clk);
      chk("fill_hs", 64'(fill_ready), 64'd1);
      chk("fill_addr", 64'(mem_addr), 64'(i));
      tick();
    end
    fill_valid = 1'b0;
    fill_last  = 1'b0;
  endtask

  typedef struct {
    logic fv; logic fl; logic rr; logic [31:0] d;
    logic e_rdy; logic [2:0] e_addr; logic [3:0] e_cnt;
  } vec_t;
  vec_t vt [8];
  logic [3:0] rdy_pat = 4'b1001;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) w[i] = 32'h1000_0000 * (i + 1) + 32'h0000_0101 * i + 32'h5a;
    reset = 1'b1; fill_valid = 1'b1; fill_data = w[0]; fill_last = 1'b0;
    rep_req = 1'b0; rep_ready = 1'b0; inv_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fill_ready", 64'(fill_ready), 64'd0);
    chk("rst_rep_valid", 64'(rep_valid), 64'd0);
    chk("rst_inv_done", 64'(inv_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rep_data", 64'(rep_data), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    fill_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Fill table: bubbles, rep_req ignored in IDLE/FILL, close on the 4th word.
    vt[0] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 3'd0, 4'd0};
    vt[1] = '{1'b1, 1'b0, 1'b1, w[0],   1'b1, 3'd0, 4'd0};
    vt[2] = '{1'b1, 1'b0, 1'b1, w[1],   1'b1, 3'd1, 4'd0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 4'd0};
    vt[4] = '{1'b1, 1'b0, 1'b0, w[2],   1'b1, 3'd2, 4'd0};
    vt[5] = '{1'b1, 1'b1, 1'b0, w[3],   1'b1, 3'd3, 4'd0};
    vt[6] = '{1'b1, 1'b0, 1'b0, w[4],   1'b0, 3'd0, 4'd4};
    vt[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 4'd4};
    for (int i = 0; i < 8; i++) begin
      fill_valid = vt[i].fv; fill_last = vt[i].fl; rep_req = vt[i].rr; fill_data = vt[i].d;
      @(negedge clk);
      chk("vec_ready", 64'(fill_ready), 64'(vt[i].e_rdy));
      chk("vec_we", 64'(mem_we), 64'(vt[i].e_rdy));
      if (vt[i].e_rdy) begin
        chk("vec_addr", 64'(mem_addr), 64'(vt[i].e_addr));
        chk("vec_wdata", 64'(mem_wdata[31:0]), 64'(vt[i].d));
      end
      chk("vec_count", 64'(count), 64'(vt[i].e_cnt));
      tick();
    end
    fill_valid = 1'b0; fill_last = 1'b0; rep_req = 1'b0;
    for (int i = 0; i < 4; i++) chk("ram_fill", 64'(ram[i][31:0]), 64'(w[i]));

    // Continuous replay: latency 2, then one word per cycle, wrapping at count.
    for (int k = 0; k < 10; k++) exp_q.push_back(w[k % 4]);
    delivered = 0;
    rep_req = 1'b1; rep_ready = 1'b1;
    @(negedge clk); chk("lat_t0", 64'(rep_valid), 64'd0); tick();
    @(negedge clk); chk("lat_t1", 64'(rep_valid), 64'd0); tick();
    @(negedge clk); chk("lat_t2", 64'(rep_valid), 64'd1); tick();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); chk("sustain", 64'(rep_valid), 64'd1); tick();
    end
    rep_req = 1'b0; rep_ready = 1'b0;
    chk("rep1_count", 64'(delivered), 64'd10);
    tick();
    @(negedge clk);
    chk("rep1_discard", 64'(rep_valid), 64'd0);
    chk("rep1_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Stalling consumer: ready pattern 1,0,0,1, restart from entry 0.
    for (int k = 0; k < 8; k++) exp_q.push_back(w[k % 4]);
    delivered = 0;
    rep_req = 1'b1;
    for (int c = 0; c < 60 && delivered < 8; c++) begin
      rep_ready = rdy_pat[3 - (c % 4)];
      @(negedge clk);
      tick();
    end
    rep_req = 1'b0; rep_ready = 1'b0;
    chk("rep2_count", 64'(delivered), 64'd8);
    chk("rep2_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Invalidate while the third word is on the output; rep_req stays high.
    exp_q.push_back(w[0]); exp_q.push_back(w[1]);
    delivered = 0;
    rep_req = 1'b1; rep_ready = 1'b1;
    for (int n = 0; n < 20 && delivered < 2; n++) begin
      @(negedge clk);
      tick();
    end
    chk("rep3_count", 64'(delivered), 64'd2);
    rep_ready = 1'b0; inv_req = 1'b1;
    @(negedge clk);
    chk("inv_noread", 64'(mem_en), 64'd0);
    tick();
    inv_req = 1'b0; rep_ready = 1'b1;
    check_inval("inv", 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_inv_rv", 64'(rep_valid), 64'd0);
      chk("post_inv_en", 64'(mem_en), 64'd0);
      tick();
    end
    rep_req = 1'b0; rep_ready = 1'b0;
    chk("rep3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Overflow: DEPTH words without a closing branch.
    fill_loop(8, 1'b0);
    check_inval("ovf", 1'b1, 1'b0);

`ifdef UOP_CACHE_PARITY_EN
    // Corrupted entry 1: w0 delivered, w1 suppressed, block invalidates.
    fill_loop(4, 1'b1);
    corrupt = 1'b1;
    exp_q.push_back(w[0]);
    delivered = 0;
    rep_req = 1'b1; rep_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      tick();
    end
    check_inval("par", 1'b0, 1'b1);
    rep_req = 1'b0; rep_ready = 1'b0; corrupt = 1'b0;
    chk("par_count", 64'(delivered), 64'd1);
    chk("par_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

    // Asynchronous reset in the middle of a replay.
    fill_loop(4, 1'b1);
    exp_q.push_back(w[0]); exp_q.push_back(w[1]);
    delivered = 0;
    rep_req = 1'b1; rep_ready = 1'b1;
    for (int n = 0; n < 20 && delivered < 2; n++) begin
      @(negedge clk);
      tick();
    end
    rep_req = 1'b0; rep_ready = 1'b0;
    fill_valid = 1'b1; fill_data = w[5];
    reset = 1'b1;
    #2;
    chk("arst_rv", 64'(rep_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_rdata", 64'(rep_data), 64'd0);
    chk("arst_ready", 64'(fill_ready), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("arst_refill", 64'(fill_ready), 64'd1);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    tick();
    fill_valid = 1'b0;
    chk("arst_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
